// File: rtl/cp0_ex_ctrl.sv
// pms-stage CP0 driver: resolves exceptions/interrupts/ERET of two in-order slots,
// gates mtc0 writes, kills younger work and holds a registered fetch redirect.
module cp0_ex_ctrl #(
  parameter logic [31:0] EX_VECTOR = 32'hBFC0_0380
) (
  input  logic        cp0_clk,
  input  logic        reset,
  input  logic        pms_go,
  input  logic        i1_valid,
  input  logic [31:0] i1_pc,
  input  logic        i1_ex,
  input  logic [4:0]  i1_excode,
  input  logic [31:0] i1_badvaddr,
  input  logic        i1_bd,
  input  logic        i1_eret,
  input  logic        i1_mtc0,
  input  logic [7:0]  i1_c0_addr,
  input  logic [31:0] i1_c0_wdata,
  input  logic        i2_valid,
  input  logic [31:0] i2_pc,
  input  logic        i2_ex,
  input  logic [4:0]  i2_excode,
  input  logic [31:0] i2_badvaddr,
  input  logic        i2_bd,
  input  logic        i2_eret,
  input  logic        i2_mtc0,
  input  logic [7:0]  i2_c0_addr,
  input  logic [31:0] i2_c0_wdata,
  input  logic        has_int,
  input  logic [31:0] epc_res,
  output logic        inst1_mtc0_we,
  output logic [7:0]  inst1_c0_addr,
  output logic [31:0] inst1_c0_wdata,
  output logic        inst2_mtc0_we,
  output logic [7:0]  inst2_c0_addr,
  output logic [31:0] inst2_c0_wdata,
  output logic        pms_ex,
  output logic [4:0]  ex_type,
  output logic        pms_bd,
  output logic [31:0] pms_pc,
  output logic [31:0] pms_badvaddr,
  output logic        pms_eret,
  output logic        i1_commit,
  output logic        i2_commit,
  output logic        flush_valid,
  output logic [31:0] flush_pc,
  input  logic        flush_ready,
  output logic        ctrl_busy
);

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t      r_state;
  logic        r_flush_valid;
  logic [31:0] r_flush_pc;
  logic        r_busy;

  logic        w_fire, w_t1, w_t2, w_ex_sel, w_eret_sel, w_c1, w_fwd;
  logic [31:0] w_target;

  assign w_fire     = pms_go & (r_state == S_IDLE) & ~reset;
  assign w_t1       = i1_valid & (has_int | i1_ex | i1_eret);
  assign w_t2       = i2_valid & (i2_ex | i2_eret);
  // An exception (or interrupt) in the selected slot outranks its ERET.
  assign w_ex_sel   = w_t1 ? (has_int | i1_ex) : (i2_valid & i2_ex);
  assign w_eret_sel = w_t1 ? (i1_eret & ~has_int & ~i1_ex) : (w_t2 & i2_eret & ~i2_ex);
  assign w_c1       = w_fire & i1_valid & ~w_t1;

  assign i1_commit     = w_c1;
  assign inst1_mtc0_we = w_c1 & i1_mtc0;
  assign i2_commit     = w_fire & i2_valid & ~w_t1 & ~w_t2;
  assign inst2_mtc0_we = i2_commit & i2_mtc0;

  assign inst1_c0_addr  = i1_c0_addr;
  assign inst1_c0_wdata = i1_c0_wdata;
  assign inst2_c0_addr  = i2_c0_addr;
  assign inst2_c0_wdata = i2_c0_wdata;

  assign pms_ex       = w_fire & w_ex_sel;
  assign pms_eret     = w_fire & w_eret_sel;
  assign ex_type      = ~pms_ex ? 5'h00 : (w_t1 ? (has_int ? 5'h00 : i1_excode) : i2_excode);
  assign pms_bd       = pms_ex & (w_t1 ? i1_bd : i2_bd);
  assign pms_pc       = ~pms_ex ? 32'h0 : (w_t1 ? i1_pc : i2_pc);
  assign pms_badvaddr = ~pms_ex ? 32'h0 : (w_t1 ? i1_badvaddr : i2_badvaddr);

  // Slot-1 MTC0 to EPC retires in the same cycle as a slot-2 ERET; CP0 EPC is still stale.
  assign w_fwd    = ~w_t1 & w_eret_sel & w_c1 & i1_mtc0 & (i1_c0_addr == 8'h70);
  assign w_target = w_ex_sel ? EX_VECTOR : (w_fwd ? i1_c0_wdata : epc_res);

  always_ff @(posedge cp0_clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_flush_valid <= 1'b0;
      r_flush_pc    <= 32'h0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_fire & (w_t1 | w_t2)) begin
          r_state       <= S_FLUSH;
          r_flush_valid <= 1'b1;
          r_flush_pc    <= w_target;
          r_busy        <= 1'b1;
        end
        S_FLUSH: if (flush_ready) begin
          r_state       <= S_IDLE;
          r_flush_valid <= 1'b0;
          r_busy        <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign flush_valid = r_flush_valid;
  assign flush_pc    = r_flush_pc;
  assign ctrl_busy   = r_busy;

endmodule
